if_id_skid_reg: RTL and testbench
=================================

Name: if_id_skid_reg

Overview:
- Parametrised IF/ID pipeline boundary register with valid/ready handshake and a 2-entry skid buffer.
- Sits between the fetch stage (PC, instruction memory) and decode.
- Adds per-cycle stall back-pressure, flush/bubble insertion and full throughput with a registered in_ready.
- Replaces the plain always-load IF/ID register.

Parameters:
- INSTR_W, 16, instruction width in bits.
- PC_W, 8, width of PC+1 field.
- NOP_VALUE, 16'h0000, instruction driven on out_instr when out_valid=0; must fit INSTR_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  stage can accept; registered.
- in_instr  input  INSTR_W  fetched instruction.
- in_pc_plus_1  input  PC_W  PC+1 of fetched instruction.
- flush  input  1  branch/jump redirect; kill all held entries.
- out_valid  output  1  decode holds a valid instruction.
- out_ready  input  1  decode can consume (0 = hazard stall).
- out_instr  output  INSTR_W  instruction to decode.
- out_pc_plus_1  output  PC_W  PC+1 to decode.

Behaviour:
- Reset: clk is clk; reset is reset, synchronous, active-low. While reset==0 at a clk edge, the next state is:
  - state EMPTY; out_valid=0; out_instr=NOP_VALUE; out_pc_plus_1=0; in_ready=0; skid cleared.
  - in_ready rises to 1 on the first edge with reset==1.
  - Reset mid-operation discards all entries; no partial transfer.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: 1 cycle, in_fire at edge N gives out_valid at N+1. Throughput: 1/cycle when out_ready=1.
- States: EMPTY (0 entries), ONE (main valid), TWO (main and skid valid).
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE, in_fire & out_fire -> ONE, main<=in.
  - ONE, in_fire & !out_fire -> TWO, skid<=in.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, otherwise -> hold.
  - TWO: out_fire -> ONE, main<=skid; otherwise hold. in_fire is impossible since in_ready=0.
- in_ready is a register: 1 iff next state != TWO, and reset not asserted.
- Output stability: while out_valid & !out_ready, out_instr and out_pc_plus_1 hold constant.
- Invalid outputs: when out_valid=0, out_instr=NOP_VALUE and out_pc_plus_1=0, a bubble.
- Flush:
  - flush=1 at an edge forces state EMPTY and both entries invalid.
  - An in_fire in the same cycle is dropped (wrong-path fetch).
  - An out_fire in the same cycle still counts as consumed by decode.
  - in_ready is 1 the next cycle.
  - Flush has priority over all transitions.
  - Reset has priority over flush.
- No combinational path from out_ready or flush to in_ready.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- With the macro: two extra outputs.
  - stall_cnt[15:0]: increments on each cycle with out_valid & !out_ready.
  - flush_cnt[15:0]: increments on each flush with at least one valid entry.
  - Both saturate at 16'hFFFF and clear on reset.
- Without the macro: ports and logic absent; otherwise identical behaviour.

Decomposition:
- Package if_id_pkg holds:
  - state encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - default NOP constant.
  - counter width constant PERF_CNT_W=16.
- One sub-module is natural: sat_counter, a saturating counter of width PERF_CNT_W with inc and synchronous active-low reset. It is instantiated twice, only under IF_ID_PERF_CNT_EN.

Test Plan:
- Reset then stream: reset low 3 cycles, all outputs at reset values. Release reset, in_valid=1 with instrs 16'h1111,16'h2222,16'h3333 and pc 1,2,3, out_ready=1 -> out_instr 1111/2222/3333 on consecutive cycles 1 cycle later, in_ready stays 1.
- Stall into skid: out_ready=0 while sending 16'hA001, 16'hA002 -> state TWO, in_ready=0 next cycle, out_instr holds A001. Raise out_ready -> A001 then A002 in order, nothing lost or duplicated.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, out_instr=NOP_VALUE, in_ready=1, dropped instrs never appear.
- Simultaneous flush and in_fire in ONE with out_ready=1 -> current instr consumed, incoming instr dropped, EMPTY.
- Reset asserted while in TWO -> everything cleared next edge; after release the first accepted instr 16'h5A5A is output first.
- With IF_ID_PERF_CNT_EN: 5 stall cycles and 2 flushes of valid entries -> stall_cnt=5, flush_cnt=2. A forced long stall saturates stall_cnt at 16'hFFFF.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID skid register slice.
package if_id_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   localparam logic [15:0] NOP_DEFAULT = 16'h0000;
   localparam int unsigned PERF_CNT_W  = 16;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch-to-decode handshake bundle; master drives the fetch/decode side, slave is the register.
interface if_id_skid_reg_if #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned PC_W    = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic [PC_W-1:0]    in_pc_plus_1;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc_plus_1;

   modport master (
      output in_valid, in_instr, in_pc_plus_1, flush, out_ready,
      input  in_ready, out_valid, out_instr, out_pc_plus_1
   );

   modport slave (
      input  in_valid, in_instr, in_pc_plus_1, flush, out_ready,
      output in_ready, out_valid, out_instr, out_pc_plus_1
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter
   import if_id_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inc,
   output logic [PERF_CNT_W-1:0] count
);
   logic [PERF_CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {PERF_CNT_W{1'b1}}))
         count_d = count_q + PERF_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register with valid/ready handshake and a 2-entry skid buffer.
// Optional stall/flush performance counters under IF_ID_PERF_CNT_EN.
module if_id_skid_reg
   import if_id_pkg::*;
#(
   parameter int unsigned        INSTR_W   = 16,
   parameter int unsigned        PC_W      = 8,
   parameter logic [INSTR_W-1:0] NOP_VALUE = INSTR_W'(NOP_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  reset,
   if_id_skid_reg_if.slave       bus
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0] stall_cnt,
   output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);
   state_e             state_q, state_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d;
   logic [PC_W-1:0]    main_pc_q, main_pc_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               in_fire_c, out_fire_c;

   assign in_fire_c  = bus.in_valid & in_ready_q;
   assign out_fire_c = out_valid_q & bus.out_ready;

   // Next-state and entry movement; flush overrides every transition.
   always_comb begin
      state_d      = state_q;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;

      case (state_q)
         EMPTY: begin
            if (in_fire_c) begin
               state_d      = ONE;
               main_instr_d = bus.in_instr;
               main_pc_d    = bus.in_pc_plus_1;
            end
         end
         ONE: begin
            if (in_fire_c && out_fire_c) begin
               main_instr_d = bus.in_instr;
               main_pc_d    = bus.in_pc_plus_1;
            end else if (in_fire_c) begin
               state_d      = TWO;
               skid_instr_d = bus.in_instr;
               skid_pc_d    = bus.in_pc_plus_1;
            end else if (out_fire_c) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (out_fire_c) begin
               state_d      = ONE;
               main_instr_d = skid_instr_q;
               main_pc_d    = skid_pc_q;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (bus.flush) state_d = EMPTY;

      // Invalid entries carry a bubble so decode never sees stale data.
      if (state_d == EMPTY) begin
         main_instr_d = NOP_VALUE;
         main_pc_d    = '0;
      end
      if (state_d != TWO) begin
         skid_instr_d = '0;
         skid_pc_d    = '0;
      end

      in_ready_d  = (state_d != TWO);
      out_valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= EMPTY;
         main_instr_q <= NOP_VALUE;
         main_pc_q    <= '0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         main_instr_q <= main_instr_d;
         main_pc_q    <= main_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_instr     = main_instr_q;
   assign bus.out_pc_plus_1 = main_pc_q;

`ifdef IF_ID_PERF_CNT_EN
   logic stall_inc_c, flush_inc_c;

   assign stall_inc_c = out_valid_q & ~bus.out_ready;
   assign flush_inc_c = bus.flush & (state_q != EMPTY);

   sat_counter u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc_c),
      .count (stall_cnt)
   );

   sat_counter u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc_c),
      .count (flush_cnt)
   );
`endif
endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for if_id_skid_reg; covers counters when IF_ID_PERF_CNT_EN is set.
module tb_if_id_skid_reg;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   if_id_skid_reg_if #(.INSTR_W(16), .PC_W(8)) bus ();

`ifdef IF_ID_PERF_CNT_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   if_id_skid_reg #(.INSTR_W(16), .PC_W(8), .NOP_VALUE(16'h0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef IF_ID_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [15:0] instr,
                          input logic [7:0] pc, input logic rdy);
      chk({tag, ".out_valid"},     32'(bus.out_valid),     32'(v));
      chk({tag, ".out_instr"},     32'(bus.out_instr),     32'(instr));
      chk({tag, ".out_pc_plus_1"}, 32'(bus.out_pc_plus_1), 32'(pc));
      chk({tag, ".in_ready"},      32'(bus.in_ready),      32'(rdy));
   endtask

   task automatic drive(input logic v, input logic [15:0] instr, input logic [7:0] pc,
                        input logic ordy, input logic fl);
      bus.in_valid     = v;
      bus.in_instr     = instr;
      bus.in_pc_plus_1 = pc;
      bus.out_ready    = ordy;
      bus.flush        = fl;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);

      // reset held low for 3 edges
      repeat (3) cyc();
      chk_out("reset", 1'b0, 16'h0000, 8'h00, 1'b0);

      reset = 1'b1;
      cyc();
      chk_out("release", 1'b0, 16'h0000, 8'h00, 1'b1);

      // streaming at full rate
      drive(1'b1, 16'h1111, 8'd1, 1'b1, 1'b0); cyc();
      chk_out("stream1", 1'b1, 16'h1111, 8'd1, 1'b1);
      drive(1'b1, 16'h2222, 8'd2, 1'b1, 1'b0); cyc();
      chk_out("stream2", 1'b1, 16'h2222, 8'd2, 1'b1);
      drive(1'b1, 16'h3333, 8'd3, 1'b1, 1'b0); cyc();
      chk_out("stream3", 1'b1, 16'h3333, 8'd3, 1'b1);
      drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0); cyc();
      chk_out("drain", 1'b0, 16'h0000, 8'h00, 1'b1);

      // stall into skid
      drive(1'b1, 16'hA001, 8'h10, 1'b0, 1'b0); cyc();
      chk_out("skid_one", 1'b1, 16'hA001, 8'h10, 1'b1);
      drive(1'b1, 16'hA002, 8'h11, 1'b0, 1'b0); cyc();
      chk_out("skid_two", 1'b1, 16'hA001, 8'h10, 1'b0);
      drive(1'b1, 16'hA003, 8'h12, 1'b0, 1'b0); cyc();
      chk_out("skid_hold", 1'b1, 16'hA001, 8'h10, 1'b0);
      drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0); cyc();
      chk_out("skid_pop1", 1'b1, 16'hA002, 8'h11, 1'b1);
      cyc();
      chk_out("skid_pop2", 1'b0, 16'h0000, 8'h00, 1'b1);

      // flush while full with a fetch pending
      drive(1'b1, 16'hB001, 8'h20, 1'b0, 1'b0); cyc();
      drive(1'b1, 16'hB002, 8'h21, 1'b0, 1'b0); cyc();
      chk_out("fl_two", 1'b1, 16'hB001, 8'h20, 1'b0);
      drive(1'b1, 16'hB003, 8'h22, 1'b0, 1'b1); cyc();
      chk_out("fl_two_flush", 1'b0, 16'h0000, 8'h00, 1'b1);
      drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0); cyc();
      chk_out("fl_two_after", 1'b0, 16'h0000, 8'h00, 1'b1);

      // flush coincident with in_fire and out_fire in ONE
      drive(1'b1, 16'hC001, 8'h30, 1'b1, 1'b0); cyc();
      chk_out("fl_one", 1'b1, 16'hC001, 8'h30, 1'b1);
      drive(1'b1, 16'hC002, 8'h31, 1'b1, 1'b1); cyc();
      chk_out("fl_one_flush", 1'b0, 16'h0000, 8'h00, 1'b1);
      drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0); cyc();
      chk_out("fl_one_after", 1'b0, 16'h0000, 8'h00, 1'b1);

      // reset while in TWO
      drive(1'b1, 16'hD001, 8'h40, 1'b0, 1'b0); cyc();
      drive(1'b1, 16'hD002, 8'h41, 1'b0, 1'b0); cyc();
      chk_out("rst_two", 1'b1, 16'hD001, 8'h40, 1'b0);
      reset = 1'b0;
      drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b0); cyc();
      chk_out("rst_mid", 1'b0, 16'h0000, 8'h00, 1'b0);
      reset = 1'b1;
      drive(1'b1, 16'h5A5A, 8'h5A, 1'b0, 1'b0); cyc();
      chk_out("rst_rel", 1'b0, 16'h0000, 8'h00, 1'b1);
      cyc();
      chk_out("rst_first", 1'b1, 16'h5A5A, 8'h5A, 1'b1);
      drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0); cyc();
      chk_out("rst_drain", 1'b0, 16'h0000, 8'h00, 1'b1);

`ifdef IF_ID_PERF_CNT_EN
      reset = 1'b0;
      drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      repeat (2) cyc();
      chk("cnt_reset.stall", 32'(stall_cnt), 32'd0);
      chk("cnt_reset.flush", 32'(flush_cnt), 32'd0);
      reset = 1'b1;
      cyc();
      drive(1'b1, 16'hE001, 8'h50, 1'b0, 1'b0); cyc();
      drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      repeat (5) cyc();
      chk("cnt.stall5", 32'(stall_cnt), 32'd5);
      drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b1); cyc();
      chk("cnt.flush1", 32'(flush_cnt), 32'd1);
      drive(1'b1, 16'hE002, 8'h51, 1'b1, 1'b0); cyc();
      drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b1); cyc();
      chk("cnt.flush2", 32'(flush_cnt), 32'd2);
      cyc();
      chk("cnt.flush_empty", 32'(flush_cnt), 32'd2);
      chk("cnt.stall_kept", 32'(stall_cnt), 32'd5);
      drive(1'b1, 16'hE003, 8'h52, 1'b0, 1'b0); cyc();
      drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      repeat (65540) @(posedge clk);
      #1;
      chk("cnt.stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
